intr_ctrl_multi: RTL and testbench

//  Parametrised N-source interrupt controller; successor to the fixed 3-key controller.
//  - Synchronises each source and sets a sticky pending bit (edge) or tracks level.
//  - Gates requests with mstatus.MIE and picks the lowest-numbered pending source.
//  - Defers trap entry while pc_insr (PC update in flight) is high.
//  - Tracks one trap at a time until mret. Sits between peripherals/keys and the CSR/trap unit.

---
 rtl/intr_ctrl_multi.sv | 162 ++++++++++++++++
 tb/tb_intr_ctrl_multi.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl_multi.sv
// N-source interrupt controller: synchronise, latch pending, prioritise, one trap until mret.
// Optional INTC_MASK_EN adds a per-source enable mask (i_irq_mask) applied to request/select.
module intr_ctrl_multi #(
  parameter int unsigned         NSRC        = 8,
  parameter int unsigned         SYNC_STAGES = 2,
  parameter int unsigned         IDX_W       = 4,
  parameter logic [NSRC-1:0]       EDGE_MASK = {NSRC{1'b1}},
  parameter logic [NSRC*IDX_W-1:0] IDX_TABLE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  i_irq_in,
`ifdef INTC_MASK_EN
  input  logic [NSRC-1:0]  i_irq_mask,
`endif
  input  logic             i_int_mstatus_mie,
  input  logic             i_pc_insr,
  input  logic             i_mret_en,
  output logic             o_trap_entry_en,
  output logic             o_trap_exit_en,
  output logic [IDX_W-1:0] o_int_index,
  output logic [NSRC-1:0]  o_pending,
  output logic             o_in_trap
);

  localparam int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef enum logic [1:0] {StIdle, StDefer, StTrap} state_e;

  logic [NSRC-1:0]  r_sync [SYNC_STAGES];
  logic [NSRC-1:0]  r_prev;
  logic [NSRC-1:0]  r_sticky;
  state_e           r_state;
  logic [SEL_W-1:0] r_lat;
  logic             r_entry;
  logic             r_exit;
  logic [IDX_W-1:0] r_index;
  logic             r_in_trap;

  logic [NSRC-1:0]  w_last;
  logic [NSRC-1:0]  w_fall;
  logic [NSRC-1:0]  w_mask;
  logic [NSRC-1:0]  w_en;
  logic             w_req;
  logic [SEL_W-1:0] w_sel;
  state_e           w_state_d;
  logic [SEL_W-1:0] w_lat_d;
  logic             w_enter;
  logic             w_exit;
  logic [SEL_W-1:0] w_src;
  logic [IDX_W-1:0] w_idx;
  logic [NSRC-1:0]  w_clr;

`ifdef INTC_MASK_EN
  assign w_mask = i_irq_mask;
`else
  assign w_mask = '1;
`endif

  // Sync flops idle at the inactive level so reset never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= EDGE_MASK;
      r_prev <= EDGE_MASK;
    end else begin
      r_sync[0] <= i_irq_in;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_last    = r_sync[SYNC_STAGES-1];
  assign w_fall    = r_prev & ~w_last & EDGE_MASK;
  assign o_pending = (r_sticky & EDGE_MASK) | (w_last & ~EDGE_MASK);
  assign w_en      = o_pending & w_mask;
  assign w_req     = i_int_mstatus_mie & (|w_en);

  always_comb begin
    w_sel = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_en[i]) w_sel = SEL_W'(i);
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_lat_d   = r_lat;
    w_enter   = 1'b0;
    w_exit    = 1'b0;
    w_src     = w_sel;
    case (r_state)
      StIdle: begin
        if (w_req) begin
          if (i_pc_insr) begin
            w_state_d = StDefer;
            w_lat_d   = w_sel;
          end else begin
            w_enter = 1'b1;
          end
        end
      end
      StDefer: begin
        // The latched source is kept even if a higher-priority one arrives meanwhile.
        if (!i_int_mstatus_mie) begin
          w_state_d = StIdle;
        end else if (!i_pc_insr) begin
          w_enter = 1'b1;
          w_src   = r_lat;
        end
      end
      StTrap: begin
        if (i_mret_en) begin
          w_exit    = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_enter) w_state_d = StTrap;
  end

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (w_src == SEL_W'(i)) w_idx = IDX_TABLE[i*IDX_W +: IDX_W];
    end
  end

  assign w_clr = w_enter ? ((NSRC'(1) << w_src) & EDGE_MASK) : '0;

  // A new edge in the entry cycle of the same source re-arms it (set wins over clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky  <= '0;
      r_state   <= StIdle;
      r_lat     <= '0;
      r_entry   <= 1'b0;
      r_exit    <= 1'b0;
      r_index   <= '0;
      r_in_trap <= 1'b0;
    end else begin
      r_sticky <= (r_sticky & ~w_clr) | w_fall;
      r_state  <= w_state_d;
      r_lat    <= w_lat_d;
      r_entry  <= w_enter;
      r_exit   <= w_exit;
      if (w_enter) begin
        r_index   <= w_idx;
        r_in_trap <= 1'b1;
      end else if (w_exit) begin
        r_index   <= '0;
        r_in_trap <= 1'b0;
      end
    end
  end

  assign o_trap_entry_en = r_entry;
  assign o_trap_exit_en  = r_exit;
  assign o_int_index     = r_index;
  assign o_in_trap       = r_in_trap;

endmodule

// File: tb/tb_intr_ctrl_multi.sv
// Bench for intr_ctrl_multi: per-cycle check against a behavioural model plus directed literals.
module tb_intr_ctrl_multi;

  localparam int unsigned NSRC = 8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned IDXW = 4;
  localparam logic [7:0]  EDGE = 8'h7F;          // source 7 is level-high
  localparam logic [31:0] TBL  = 32'h87654321;   // cause index of source i is i+1

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] irq = 8'h7F;
  logic [7:0] mask = 8'hFF;
  logic       mie = 1'b1;
  logic       pc = 1'b0;
  logic       mret = 1'b0;
  logic       entry, exit_en, in_trap;
  logic [3:0] idx;
  logic [7:0] pend;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  intr_ctrl_multi #(
    .NSRC(NSRC), .SYNC_STAGES(SYNC), .IDX_W(IDXW), .EDGE_MASK(EDGE), .IDX_TABLE(TBL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_irq_in(irq),
`ifdef INTC_MASK_EN
    .i_irq_mask(mask),
`endif
    .i_int_mstatus_mie(mie),
    .i_pc_insr(pc),
    .i_mret_en(mret),
    .o_trap_entry_en(entry),
    .o_trap_exit_en(exit_en),
    .o_int_index(idx),
    .o_pending(pend),
    .o_in_trap(in_trap)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: history of sampled inputs, sticky edge set, and who owns the trap.
  logic [7:0] m_hist [SYNC+1];
  logic [7:0] m_sticky;
  bit         m_trap;
  int         m_defer;
  bit         m_entry, m_exit;
  int         m_index;

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [7:0] vis, en, fall, clr;
    int s, tgt;
    if (rst) begin
      for (int k = 0; k <= SYNC; k++) m_hist[k] <= EDGE;
      m_sticky <= '0;
      m_trap   <= 1'b0;
      m_defer  <= -1;
      m_entry  <= 1'b0;
      m_exit   <= 1'b0;
      m_index  <= 0;
    end else begin
      vis  = m_sticky | (m_hist[SYNC-1] & ~EDGE);
      en   = vis & mask;
      s    = lowest(en);
      fall = m_hist[SYNC] & ~m_hist[SYNC-1] & EDGE;
      tgt  = -1;
      clr  = '0;
      m_entry <= 1'b0;
      m_exit  <= 1'b0;
      if (m_trap) begin
        if (mret) begin
          m_exit  <= 1'b1;
          m_trap  <= 1'b0;
          m_index <= 0;
        end
      end else if (m_defer >= 0) begin
        if (!mie) m_defer <= -1;
        else if (!pc) tgt = m_defer;
      end else if (mie && s >= 0) begin
        if (pc) m_defer <= s;
        else tgt = s;
      end
      if (tgt >= 0) begin
        m_entry  <= 1'b1;
        m_trap   <= 1'b1;
        m_index  <= tgt + 1;
        m_defer  <= -1;
        clr[tgt] = EDGE[tgt];
      end
      m_sticky <= (m_sticky & ~clr) | fall;
      m_hist[0] <= irq;
      for (int k = 1; k <= SYNC; k++) m_hist[k] <= m_hist[k-1];
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("entry", 32'(entry), 32'(m_entry));
      check("exit", 32'(exit_en), 32'(m_exit));
      check("in_trap", 32'(in_trap), 32'(m_trap));
      check("index", 32'(idx), 32'(m_index));
      check("pending", 32'(pend), 32'(m_sticky | (m_hist[SYNC-1] & ~EDGE)));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_mret();
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("mret_exit", 32'(exit_en), 32'd1);
    check("mret_in_trap", 32'(in_trap), 32'd0);
    check("mret_index", 32'(idx), 32'd0);
  endtask

  initial begin
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    cmp_on = 1'b1;
    check("rst_pending", 32'(pend), 32'h0);
    check("rst_in_trap", 32'(in_trap), 32'd0);
    tick(2);

    // 1: single edge on source 3
    irq[3] = 1'b0;
    tick(2);
    check("t1_pend_early", 32'(pend), 32'h0);
    tick();
    check("t1_pend", 32'(pend), 32'h08);
    check("t1_no_entry_yet", 32'(entry), 32'd0);
    tick();
    check("t1_entry", 32'(entry), 32'd1);
    check("t1_index", 32'(idx), 32'd4);
    check("t1_pend_clr", 32'(pend), 32'h0);
    irq[3] = 1'b1;
    tick();
    check("t1_entry_pulse", 32'(entry), 32'd0);
    check("t1_in_trap", 32'(in_trap), 32'd1);
    do_mret();
    tick(4);

    // mret outside a trap
    mret = 1'b1;
    tick();
    mret = 1'b0;
    check("stray_mret", 32'(exit_en), 32'd0);

    // 2: sources 5 and 2 together
    irq[5] = 1'b0;
    irq[2] = 1'b0;
    tick(3);
    check("t2_pend", 32'(pend), 32'h24);
    tick();
    check("t2_entry2", 32'(entry), 32'd1);
    check("t2_index2", 32'(idx), 32'd3);
    irq[5] = 1'b1;
    irq[2] = 1'b1;
    tick(2);
    check("t2_pend5", 32'(pend), 32'h20);
    do_mret();
    check("t2_no_entry_at_exit", 32'(entry), 32'd0);
    tick();
    check("t2_entry5", 32'(entry), 32'd1);
    check("t2_index5", 32'(idx), 32'd6);
    do_mret();
    tick(4);

    // 3: deferral while pc_insr is high; later higher-priority arrival does not displace
    pc = 1'b1;
    irq[1] = 1'b0;
    tick(3);
    check("t3_pend", 32'(pend), 32'h02);
    irq[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_deferred", 32'(entry), 32'd0);
    end
    check("t3_pend_both", 32'(pend), 32'h03);
    pc = 1'b0;
    tick();
    check("t3_entry", 32'(entry), 32'd1);
    check("t3_index", 32'(idx), 32'd2);
    irq[0] = 1'b1;
    irq[1] = 1'b1;
    do_mret();
    tick();
    check("t3_entry0", 32'(entry), 32'd1);
    check("t3_index0", 32'(idx), 32'd1);
    do_mret();
    tick(4);

    // 4: MIE low holds the request back
    mie = 1'b0;
    irq[1] = 1'b0;
    tick(3);
    check("t4_pend", 32'(pend), 32'h02);
    tick(3);
    check("t4_no_entry", 32'(in_trap), 32'd0);
    mie = 1'b1;
    tick();
    check("t4_entry", 32'(entry), 32'd1);
    check("t4_index", 32'(idx), 32'd2);
    irq[1] = 1'b1;
    do_mret();
    tick(4);

    // level source 7
    irq[7] = 1'b1;
    tick(2);
    check("lvl_pend", 32'(pend), 32'h80);
    tick();
    check("lvl_entry", 32'(entry), 32'd1);
    check("lvl_index", 32'(idx), 32'd8);
    check("lvl_pend_held", 32'(pend), 32'h80);
    irq[7] = 1'b0;
    tick(2);
    check("lvl_pend_drop", 32'(pend), 32'h0);
    do_mret();
    tick(4);

    // 5: asynchronous reset in the middle of a trap
    irq[4] = 1'b0;
    tick(4);
    check("t5_entry", 32'(entry), 32'd1);
    check("t5_index", 32'(idx), 32'd5);
    irq[4] = 1'b1;
    irq[6] = 1'b0;
    tick(3);
    check("t5_pend6", 32'(pend), 32'h40);
    irq[6] = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("t5_rst_in_trap", 32'(in_trap), 32'd0);
    check("t5_rst_index", 32'(idx), 32'd0);
    check("t5_rst_pend", 32'(pend), 32'h0);
    tick(2);
    rst = 1'b0;
    tick();
    check("t5_no_exit", 32'(exit_en), 32'd0);
    check("t5_no_trap", 32'(in_trap), 32'd0);
    tick(4);

`ifdef INTC_MASK_EN
    // 6: masked source pends but does not request until unmasked
    mask[4] = 1'b0;
    irq[4] = 1'b0;
    tick(3);
    check("t6_pend", 32'(pend), 32'h10);
    tick(2);
    check("t6_masked", 32'(in_trap), 32'd0);
    mask[4] = 1'b1;
    tick();
    check("t6_entry", 32'(entry), 32'd1);
    check("t6_index", 32'(idx), 32'd5);
    irq[4] = 1'b1;
    do_mret();
    tick(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
